// File: rtl/sample_pkg.sv
// Shared types and defaults for the sample ROM player.
// Provides the FSM state encoding, default sizes and the divider-width helper.
package sample_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StHold
    } state_e;

    localparam int unsigned DEFAULT_LENGTH = 4;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DIV   = 4;

    // Width of a counter spanning 0..div-1; never narrower than one bit.
    function automatic int unsigned div_width(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sample_rate_div.sv
// Free-running modulo-DIV counter with synchronous clear.
// tc is high while the count sits at DIV-1.
module sample_rate_div
    import sample_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam int unsigned DW = div_width(DIV);
    localparam logic [DW-1:0] TC_VAL = DW'(DIV - 1);

    logic [DW-1:0] count_q, count_d;

    assign tc = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr || tc) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_player.sv
// Reads samples 0..LENGTH-1 from a 1-cycle-latency ROM, one every DIV clocks,
// and presents each with a one-cycle valid strobe. Supports loop, stop and restart.
module sample_player
    import sample_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH,
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned ADDR   = $clog2(LENGTH),
    parameter int unsigned DIV    = DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    output logic [ADDR-1:0]         rom_addr,
    input  logic signed [WIDTH-1:0] rom_data,
    output logic signed [WIDTH-1:0] sample,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(LENGTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR-1:0]         addr_q, addr_d;
    logic signed [WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    div_tc;
    logic                    div_clr;
    logic                    abort;

    // Stop only matters while playing; a coincident start takes precedence.
    assign abort = stop && (state_q != StIdle) && !start;

    // The divider is held at zero whenever a new sample period is about to begin.
    assign div_clr = start || (state_d == StIdle) || ((state_q == StHold) && div_tc);

    sample_rate_div #(
        .DIV (DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .tc  (div_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StFetch;
        end else if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StFetch:   state_d = StCapture;
                StCapture: state_d = StHold;
                StHold: begin
                    if (div_tc) begin
                        state_d = (addr_q == LAST_ADDR && !loop) ? StIdle : StFetch;
                    end
                end
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        addr_d   = addr_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        if (start) begin
            addr_d = '0;
        end else if (abort) begin
            sample_d = '0;
        end else begin
            unique case (state_q)
                StCapture: begin
                    sample_d = rom_data;
                    valid_d  = 1'b1;
                end
                StHold: begin
                    if (div_tc) begin
                        if (addr_q != LAST_ADDR) begin
                            addr_d = addr_q + 1'b1;
                        end else if (loop) begin
                            addr_d = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr     = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign done         = done_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: one-shot, loop, restart, stop and reset on a
// 4-entry/DIV=4 instance, plus a 2-entry/DIV=3 boundary instance.
module tb_sample_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, stop_a, loop_a, start_b, stop_b, loop_b;

    logic [1:0]        addr_a;
    logic signed [7:0] data_a, sample_a;
    logic              valid_a, busy_a, done_a;

    logic [0:0]        addr_b;
    logic signed [7:0] data_b, sample_b;
    logic              valid_b, busy_b, done_b;

    int passed = 0;
    int total  = 0;
    logic exp_v;

    sample_player #(.LENGTH(4), .WIDTH(8), .ADDR(2), .DIV(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .loop(loop_a),
        .rom_addr(addr_a), .rom_data(data_a), .sample(sample_a),
        .sample_valid(valid_a), .busy(busy_a), .done(done_a)
    );

    sample_player #(.LENGTH(2), .WIDTH(8), .ADDR(1), .DIV(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .loop(loop_b),
        .rom_addr(addr_b), .rom_data(data_b), .sample(sample_b),
        .sample_valid(valid_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic signed [7:0] rom_a(input logic [1:0] a);
        case (a)
            2'd0:    return 8'sh10;
            2'd1:    return 8'sh20;
            2'd2:    return 8'shF0;
            default: return 8'sh7F;
        endcase
    endfunction

    function automatic logic signed [7:0] rom_b(input logic [0:0] a);
        return a[0] ? 8'shAA : 8'sh55;
    endfunction

    always_ff @(posedge clk) begin
        data_a <= rom_a(addr_a);
        data_b <= rom_b(addr_b);
    end

    function automatic int exp_a(input int i);
        case (i)
            0:       return 16;
            1:       return 32;
            2:       return -16;
            default: return 127;
        endcase
    endfunction

    function automatic int exp_b(input int i);
        return (i == 0) ? 85 : -86;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc,
                         input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0;
        tick();
        tick();
        check("rst_addr_a", 0, addr_a, 0);
        check("rst_sample_a", 0, sample_a, 0);
        check("rst_valid_a", 0, valid_a, 0);
        check("rst_busy_a", 0, busy_a, 0);
        check("rst_done_a", 0, done_a, 0);
        check("rst_busy_b", 0, busy_b, 0);
        check("rst_sample_b", 0, sample_b, 0);
        rst = 1'b0;
        tick();

        // One-shot: strobes at +2,+6,+10,+14, done at +16.
        loop_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("os_busy0", 0, busy_a, 1);
        check("os_addr0", 0, addr_a, 0);
        check("os_valid0", 0, valid_a, 0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            exp_v = (c % 4 == 2) && (c <= 14);
            check("os_valid", c, valid_a, exp_v);
            if (exp_v) check("os_sample", c, sample_a, exp_a((c - 2) / 4));
            check("os_done", c, done_a, c == 16);
            check("os_busy", c, busy_a, c < 16);
        end
        check("os_hold", 18, sample_a, 127);

        // Loop: ten periods, strobes every 4 cycles across the wrap, no done.
        loop_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            tick();
            exp_v = (c % 4 == 2);
            check("lp_valid", c, valid_a, exp_v);
            if (exp_v) check("lp_sample", c, sample_a, exp_a(((c - 2) / 4) % 4));
            check("lp_done", c, done_a, 0);
            check("lp_busy", c, busy_a, 1);
        end
        check("rs_addr_pre", 41, addr_a, 2);

        // Restart at address 2: due strobe suppressed, sample held, 16 two cycles later.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("rs_addr", 0, addr_a, 0);
        check("rs_valid0", 0, valid_a, 0);
        check("rs_hold0", 0, sample_a, 32);
        tick();
        check("rs_valid1", 1, valid_a, 0);
        check("rs_hold1", 1, sample_a, 32);
        tick();
        check("rs_valid2", 2, valid_a, 1);
        check("rs_sample2", 2, sample_a, 16);
        for (int r = 3; r <= 8; r++) begin
            tick();
            check("rs_valid", r, valid_a, r == 6);
            if (r == 6) check("rs_sample", r, sample_a, 32);
        end

        // Stop two cycles after the second strobe.
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        check("sp_busy", 0, busy_a, 0);
        check("sp_sample", 0, sample_a, 0);
        check("sp_valid", 0, valid_a, 0);
        check("sp_done", 0, done_a, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("sp_valid_q", i, valid_a, 0);
            check("sp_done_q", i, done_a, 0);
        end
        loop_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check("sp_replay_v", 2, valid_a, 1);
        check("sp_replay_s", 2, sample_a, 16);

        // Reset while in HOLD.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_addr", 0, addr_a, 0);
        check("mr_sample", 0, sample_a, 0);
        check("mr_valid", 0, valid_a, 0);
        check("mr_busy", 0, busy_a, 0);
        check("mr_done", 0, done_a, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("mr_valid_q", i, valid_a, 0);
            check("mr_busy_q", i, busy_a, 0);
        end

        // Boundary instance: DIV=3, LENGTH=2, looping.
        loop_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp_v = (c % 3 == 2);
            check("b_valid", c, valid_b, exp_v);
            if (exp_v) check("b_sample", c, sample_b, exp_b(((c - 2) / 3) % 2));
            check("b_addr", c, addr_b, (c / 3) % 2);
            check("b_done", c, done_b, 0);
        end

        // Boundary one-shot via restart: done lands one cycle after the last strobe.
        loop_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("bo_valid", c, valid_b, (c == 2) || (c == 5));
            check("bo_done", c, done_b, c == 6);
            check("bo_busy", c, busy_b, c < 6);
            check("bo_addr", c, addr_b, c >= 3);
        end
        check("bo_hold", 8, sample_b, -86);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sample_player.md
Name: sample_player

Overview:
- Reader-side sequencer for the synchronous sample ROM.
- On a start pulse it walks ROM addresses 0..LENGTH-1 at a fixed sample rate (one sample every DIV clocks).
- It absorbs the ROM's 1-cycle read latency and presents each signed sample with a one-cycle valid strobe to the downstream PWM/DAC stage.
- Supports one-shot and looped playback, plus stop/restart.

Parameters:
- LENGTH, `SAMPLES_LENGTH, number of samples in the ROM (>=2).
- WIDTH, 8, sample width in bits, signed.
- ADDR, $clog2(LENGTH), ROM address width.
- DIV, 4, clock cycles per output sample (>=3); sets the sample rate as clk/DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begin (or restart) playback at address 0
- stop  in  1  one-cycle pulse; abort playback
- loop  in  1  sampled at every end-of-table; 1 = wrap to 0, 0 = finish
- rom_addr  out  ADDR  address to the sample ROM
- rom_data  in  WIDTH signed  ROM read data; valid one clock after rom_addr
- sample  out  WIDTH signed  current output sample, held between strobes
- sample_valid  out  1  one-cycle strobe; sample has just been updated
- busy  out  1  high while playing
- done  out  1  one-cycle pulse at the end of one-shot playback

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, regardless of state, including mid-playback:
  - state IDLE, rom_addr=0, sample=0, sample_valid=0, busy=0, done=0, divider=0.
- States:
  - IDLE: waiting for start.
  - FETCH: rom_addr is presented to the ROM.
  - CAPTURE: rom_data is valid and is registered.
  - HOLD: wait out the remainder of the sample period.
- IDLE:
  - start -> rom_addr<=0, divider<=0, busy<=1, go to FETCH.
- FETCH (divider counts 0):
  - Go to CAPTURE next cycle; rom_addr is stable.
- CAPTURE (divider=1):
  - sample<=rom_data and sample_valid<=1 for exactly this one registered cycle.
  - Go to HOLD.
- HOLD: divider increments each cycle. At divider=DIV-1:
  - If rom_addr != LENGTH-1: rom_addr<=rom_addr+1, divider<=0, go to FETCH.
  - If rom_addr == LENGTH-1 and loop=1: rom_addr<=0, divider<=0, go to FETCH. No gap and no done pulse.
  - If rom_addr == LENGTH-1 and loop=0: done<=1 (one cycle), busy<=0, go to IDLE. sample keeps the last value.
- Timing:
  - start at edge T gives the first sample_valid at T+2 with sample = ROM[0].
  - Consecutive sample_valid strobes are exactly DIV cycles apart, including across a loop wrap.
- Address never exceeds LENGTH-1; there is no power-of-two assumption.
- stop while busy:
  - Next edge: IDLE, busy=0, sample<=0 (silence), no done pulse.
  - A sample_valid due on that edge is suppressed.
- start while busy: restart as from IDLE (rom_addr<=0, FETCH); the current sample is held until the new strobe.
- start and stop on the same edge: start wins (restart).
- stop while IDLE: no effect.
- sample_valid and done are never high together except on a one-shot final period? No: done fires DIV-2 cycles after the last strobe, so they are never coincident.

Decomposition:
- Shared package sample_pkg:
  - State encoding constants (IDLE, FETCH, CAPTURE, HOLD).
  - Default WIDTH.
  - Divider width, $clog2(DIV).
- One sub-module is natural: sample_rate_div, a free-standing DIV counter with a synchronous clear and a terminal-count output, used by the HOLD logic.
- The ROM itself stays external; the player only drives rom_addr and consumes rom_data.

Test Plan:
- Setup: LENGTH=4, DIV=4, ROM model with 1-cycle latency holding {0x10,0x20,0xF0,0x7F}.
- One-shot: start, loop=0 -> sample_valid at T+2, T+6, T+10, T+14 with samples 16, 32, -16, 127; done at T+16; busy low from T+16; sample stays 127.
- Loop: loop=1, run 10 periods -> strobe sequence 16, 32, -16, 127, 16, 32, ..., strobes spaced exactly 4 cycles across the wrap; done never asserted.
- Stop mid-play: stop two cycles after the second strobe -> next edge busy=0, sample=0, no further sample_valid, no done; a later start replays from 16.
- Restart: start pulse while rom_addr=2 -> rom_addr=0 next edge; next strobe carries 16 two cycles later.
- Reset mid-play: rst high for 1 cycle during HOLD -> all outputs 0 on that edge; no strobe until a new start.
- Boundary: DIV=3, LENGTH=2 -> strobes every 3 cycles, addresses 0,1 only; rom_addr never equals 2.
